// File: rtl/io_port_bank.sv
// -----------------------------------------------------------------------------
// io_port_bank
//
// A bank of NPORTS addressable I/O ports, each DW bits wide.
// - Writes latch wdata into one output-port slice and fire a one-hot write
//   strobe on the following cycle.
// - Reads return the synchronized value of one input-port slice, with rd_valid
//   and a one-hot read strobe on the following cycle.
// - Each input slice has a sticky change flag. A read of that port clears it,
//   but a change seen on the same edge wins over the clear.
// - An access to an address that does not exist only pulses addr_err.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   rst_n      : asynchronous active-low reset
//   addr       : port address of the current access (AW bits)
//   wr_en      : write request
//   rd_en      : read request
//   wdata      : write data (DW bits)
//   in_ports   : asynchronous external inputs, port k at [k*DW +: DW]
//   out_ports  : latched output ports, same slicing as in_ports
//   rdata      : registered read data
//   rd_valid   : one-cycle pulse qualifying rdata
//   wr_strobe  : registered one-hot write strobe (NPORTS bits)
//   rd_strobe  : registered one-hot read strobe (NPORTS bits)
//   chg_flags  : sticky per-port input-change flags (NPORTS bits)
//   addr_err   : one-cycle pulse on an access to addr >= NPORTS
// -----------------------------------------------------------------------------
module io_port_bank #(
  parameter int AW     = 4,
  parameter int NPORTS = 16,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        addr,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [DW-1:0]        wdata,
  input  logic [NPORTS*DW-1:0] in_ports,
  output logic [NPORTS*DW-1:0] out_ports,
  output logic [DW-1:0]        rdata,
  output logic                 rd_valid,
  output logic [NPORTS-1:0]    wr_strobe,
  output logic [NPORTS-1:0]    rd_strobe,
  output logic [NPORTS-1:0]    chg_flags,
  output logic                 addr_err
);

  // One bit wider than addr, so that NPORTS == 2**AW is still representable.
  localparam logic [AW:0] PortCount = (AW+1)'(NPORTS);

  logic [NPORTS*DW-1:0] outPorts_q, outPorts_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 rdValid_q, rdValid_d;
  logic [NPORTS-1:0]    wrStrobe_q, wrStrobe_d;
  logic [NPORTS-1:0]    rdStrobe_q, rdStrobe_d;
  logic [NPORTS-1:0]    chgFlags_q, chgFlags_d;
  logic                 addrErr_q, addrErr_d;
  logic [NPORTS*DW-1:0] sync1_q, sync2_q, prev_q;
  logic [1:0]           warm_q, warm_d;

  logic                 inRange;
  logic                 wrHit;
  logic                 rdHit;
  logic                 warmDone;
  logic [NPORTS-1:0]    addrOneHot;
  logic [NPORTS-1:0]    chgSet;

  // warm_q counts the first three edges after reset release. Until then, the
  // synchronizer and previous-value registers still hold reset zeros. Any
  // difference seen in that window comes from the release itself, not from
  // a real input change.
  assign warmDone = (warm_q == 2'd3);

  always_comb begin
    inRange    = ({1'b0, addr} < PortCount);
    wrHit      = wr_en & inRange;
    rdHit      = rd_en & inRange;
    warm_d     = warmDone ? warm_q : warm_q + 2'd1;
    outPorts_d = outPorts_q;
    rdata_d    = rdata_q;
    addrOneHot = '0;
    chgSet     = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (addr == AW'(k)) begin
        addrOneHot[k] = 1'b1;
        if (wrHit) outPorts_d[k*DW +: DW] = wdata;
        if (rdHit) rdata_d = sync2_q[k*DW +: DW];
      end
      chgSet[k] = warmDone && (sync2_q[k*DW +: DW] != prev_q[k*DW +: DW]);
    end
    wrStrobe_d = wrHit ? addrOneHot : '0;
    rdStrobe_d = rdHit ? addrOneHot : '0;
    rdValid_d  = rdHit;
    addrErr_d  = (wr_en | rd_en) & ~inRange;
    // The set term is OR-ed in after the clear, so a change that lands on
    // the same edge as a read is never lost.
    chgFlags_d = (chgFlags_q & ~rdStrobe_d) | chgSet;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outPorts_q <= '0;
      rdata_q    <= '0;
      rdValid_q  <= 1'b0;
      wrStrobe_q <= '0;
      rdStrobe_q <= '0;
      chgFlags_q <= '0;
      addrErr_q  <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      warm_q     <= 2'd0;
    end else begin
      outPorts_q <= outPorts_d;
      rdata_q    <= rdata_d;
      rdValid_q  <= rdValid_d;
      wrStrobe_q <= wrStrobe_d;
      rdStrobe_q <= rdStrobe_d;
      chgFlags_q <= chgFlags_d;
      addrErr_q  <= addrErr_d;
      sync1_q    <= in_ports;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      warm_q     <= warm_d;
    end
  end

  assign out_ports = outPorts_q;
  assign rdata     = rdata_q;
  assign rd_valid  = rdValid_q;
  assign wr_strobe = wrStrobe_q;
  assign rd_strobe = rdStrobe_q;
  assign chg_flags = chgFlags_q;
  assign addr_err  = addrErr_q;

endmodule

// File: tb/tb_io_port_bank.sv
// -----------------------------------------------------------------------------
// tb_io_port_bank
//
// Testbench for io_port_bank, configured with 12 ports so that out-of-range
// addresses exist. The reference model keeps a history of the input-port
// values sampled at each edge since reset release. The synchronized value
// seen at edge n is the input sampled at edge n-2. A change is detectable
// from edge 4 on, once that history holds real samples.
// -----------------------------------------------------------------------------
module tb_io_port_bank;

  localparam int AW = 4;
  localparam int NP = 12;
  localparam int DW = 4;
  localparam int W  = NP * DW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wdata;
  logic [W-1:0]  in_ports;
  logic [W-1:0]  out_ports;
  logic [DW-1:0] rdata;
  logic          rd_valid;
  logic [NP-1:0] wr_strobe;
  logic [NP-1:0] rd_strobe;
  logic [NP-1:0] chg_flags;
  logic          addr_err;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state.
  logic [W-1:0]  outM;
  logic [DW-1:0] rdataM;
  logic          rdValidM;
  logic [NP-1:0] wrStrobeM;
  logic [NP-1:0] rdStrobeM;
  logic [NP-1:0] flagsM;
  logic          addrErrM;
  logic [W-1:0]  inHist [0:1023];
  int            edgeN;

  io_port_bank #(.AW(AW), .NPORTS(NP), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wdata     (wdata),
    .in_ports  (in_ports),
    .out_ports (out_ports),
    .rdata     (rdata),
    .rd_valid  (rd_valid),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .chg_flags (chg_flags),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".out_ports"}, 64'(out_ports), 64'(outM));
    checkVal({tag, ".rdata"},     64'(rdata),     64'(rdataM));
    checkVal({tag, ".rd_valid"},  64'(rd_valid),  64'(rdValidM));
    checkVal({tag, ".wr_strobe"}, 64'(wr_strobe), 64'(wrStrobeM));
    checkVal({tag, ".rd_strobe"}, 64'(rd_strobe), 64'(rdStrobeM));
    checkVal({tag, ".chg_flags"}, 64'(chg_flags), 64'(flagsM));
    checkVal({tag, ".addr_err"},  64'(addr_err),  64'(addrErrM));
  endtask

  task automatic modelReset();
    outM      = '0;
    rdataM    = '0;
    rdValidM  = 1'b0;
    wrStrobeM = '0;
    rdStrobeM = '0;
    flagsM    = '0;
    addrErrM  = 1'b0;
    edgeN     = 0;
  endtask

  // Applies the port rules to the inputs sampled at the current edge.
  task automatic modelEdge();
    int            a;
    bit            inR;
    logic [NP-1:0] oh;
    logic [NP-1:0] setv;
    logic [W-1:0]  h2;
    logic [W-1:0]  h3;
    a    = int'(addr);
    inR  = (a < NP);
    oh   = '0;
    setv = '0;
    if (inR) oh[a] = 1'b1;
    h2 = (edgeN >= 3) ? inHist[edgeN-2] : '0;
    h3 = (edgeN >= 4) ? inHist[edgeN-3] : '0;
    if (edgeN >= 4) begin
      for (int k = 0; k < NP; k++)
        if (h2[k*DW +: DW] != h3[k*DW +: DW]) setv[k] = 1'b1;
    end
    wrStrobeM = (wr_en && inR) ? oh : '0;
    rdStrobeM = (rd_en && inR) ? oh : '0;
    rdValidM  = rd_en && inR;
    addrErrM  = (wr_en || rd_en) && !inR;
    if (wr_en && inR) outM[a*DW +: DW] = wdata;
    if (rd_en && inR) rdataM = h2[a*DW +: DW];
    flagsM = (flagsM & ~rdStrobeM) | setv;
  endtask

  // Inputs are already driven. Advance one edge, update the model, then
  // check all outputs 1 ns after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    edgeN++;
    inHist[edgeN] = in_ports;
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input string tag, input logic w, input logic r,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    addr  = a;
    wdata = d;
    step(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [W-1:0] outBefore;
    logic [W-1:0] rnd;

    // Reset with nonzero inputs: releasing reset must not raise any flag.
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    addr     = '0;
    wdata    = '0;
    in_ports = 48'h5A3_C96_F01_B2E;
    modelReset();
    #3;
    checkOutput("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("postReset", 6);
    checkVal("noFlagsAfterRelease", 64'(chg_flags), 64'h0);

    // Write to port 5.
    applyStimulus("wr5", 1'b1, 1'b0, 4'd5, 4'hA);
    checkVal("wr5.slice", 64'(out_ports[23:20]), 64'hA);
    checkVal("wr5.strobe", 64'(wr_strobe), 64'h020);
    idle("wr5.after", 1);
    checkVal("wr5.strobeDrop", 64'(wr_strobe), 64'h0);

    // Change slice 3 to 0x7, then read it back.
    in_ports[15:12] = 4'h7;
    idle("chg3", 3);
    checkVal("chg3.flagBefore", 64'(chg_flags[3]), 64'h1);
    applyStimulus("rd3", 1'b0, 1'b1, 4'd3, 4'h0);
    checkVal("rd3.rdata", 64'(rdata), 64'h7);
    checkVal("rd3.strobe", 64'(rd_strobe), 64'h008);
    checkVal("rd3.flagAfter", 64'(chg_flags[3]), 64'h0);

    // Out-of-range write.
    outBefore = out_ports;
    applyStimulus("oob13", 1'b1, 1'b0, 4'd13, 4'hF);
    checkVal("oob13.err", 64'(addr_err), 64'h1);
    checkVal("oob13.outHold", 64'(out_ports), 64'(outBefore));
    idle("oob13.after", 1);
    checkVal("oob13.errDrop", 64'(addr_err), 64'h0);

    // Simultaneous write and read to port 2.
    in_ports[11:8] = 4'hC;
    idle("sync2", 3);
    applyStimulus("wrrd2", 1'b1, 1'b1, 4'd2, 4'h5);
    checkVal("wrrd2.out", 64'(out_ports[11:8]), 64'h5);
    checkVal("wrrd2.rdata", 64'(rdata), 64'hC);
    checkVal("wrrd2.strobes", 64'({wr_strobe, rd_strobe}), {40'h0, 12'h004, 12'h004});

    // Slice 1 reaches the synchronized domain on the edge that reads port 1.
    in_ports[7:4] = ~in_ports[7:4];
    idle("tog1", 2);
    applyStimulus("tog1.rd", 1'b0, 1'b1, 4'd1, 4'h0);
    checkVal("tog1.flagKept", 64'(chg_flags[1]), 64'h1);

    // Randomized back-to-back traffic, including out-of-range addresses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rnd = W'({$urandom, $urandom});
        in_ports[$urandom_range(0, NP-1)*DW +: DW] = rnd[DW-1:0];
      end
      applyStimulus("rand", 1'(($urandom_range(0, 2)) != 0), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), DW'($urandom));
    end

    // Reset asserted mid-burst, then the first write after release.
    applyStimulus("burst", 1'b1, 1'b0, 4'd9, 4'h6);
    applyStimulus("burst", 1'b1, 1'b1, 4'd4, 4'h3);
    checkVal("burst.nonzero", 64'(out_ports != '0), 64'h1);
    wr_en = 1'b1;
    addr  = 4'd6;
    wdata = 4'hE;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midReset");
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("firstWr", 1'b1, 1'b0, 4'd7, 4'h9);
    checkVal("firstWr.slice", 64'(out_ports[31:28]), 64'h9);
    checkVal("firstWr.strobe", 64'(wr_strobe), 64'h080);
    idle("firstWr.after", 5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 SHALL have parameter AW, default 4: port-address width.
REQ-002 SHALL have parameter NPORTS, default 16: number of ports, 1..2**AW.
REQ-003 SHALL have parameter DW, default 4: data width per port.
REQ-004 SHALL have port clk  input  1: single clock, all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port addr  input  AW: port address for the current access.
REQ-007 SHALL have port wr_en  input  1: write request, sampled at clk edge.
REQ-008 SHALL have port rd_en  input  1: read request, sampled at clk edge.
REQ-009 SHALL have port wdata  input  DW: write data.
REQ-010 SHALL have port in_ports  input  NPORTS*DW: asynchronous external inputs; port k occupies bits [k*DW +: DW].
REQ-011 SHALL have port out_ports  output  NPORTS*DW: latched output ports, same slicing as in_ports.
REQ-012 SHALL have port rdata  output  DW: registered read data.
REQ-013 SHALL have port rd_valid  output  1: one-cycle pulse qualifying rdata.
REQ-014 SHALL have port wr_strobe  output  NPORTS: registered one-hot write strobe.
REQ-015 SHALL have port rd_strobe  output  NPORTS: registered one-hot read strobe.
REQ-016 SHALL have port chg_flags  output  NPORTS: sticky per-port input-change flags.
REQ-017 SHALL have port addr_err  output  1: one-cycle pulse on an access to addr >= NPORTS.

Function
REQ-018 SHALL treat an access as in range when addr < NPORTS.
REQ-019 SHALL, at an edge with wr_en=1 and addr in range, load out_ports slice addr with wdata; all other slices hold.
REQ-020 SHALL assert wr_strobe[addr] for exactly the one cycle after that edge (latency 1), with all other bits 0.
REQ-021 SHALL keep wr_strobe all-zero on any cycle not following a valid write, including cycles following wr_en=0.
REQ-022 SHALL pass each in_ports slice through a two-flop synchronizer; all reads and change detection use the synchronized value only.
REQ-023 SHALL, at an edge with rd_en=1 and addr in range, load rdata with the synchronized slice addr.
REQ-024 SHALL, after such a read edge, pulse rd_valid and rd_strobe[addr] for exactly one cycle (latency 1).
REQ-025 SHALL hold rdata between reads.
REQ-026 SHALL keep wr_strobe and rd_strobe each at most one-hot at all times.
REQ-027 SHALL, at every edge, set chg_flags[k] when the synchronized slice k differs from its value on the previous cycle.
REQ-028 SHALL clear chg_flags[k] on a valid read of port k.
REQ-029 SHALL leave chg_flags[k] set when a set and a clear for k occur on the same edge (set wins, no lost event).
REQ-030 SHALL process wr_en=1 and rd_en=1 on the same edge independently: both strobes fire on the same address, and rdata returns the input port, not wdata.
REQ-031 SHALL, for wr_en or rd_en with addr >= NPORTS, leave out_ports, rdata and chg_flags unchanged, fire no strobe or rd_valid, and pulse addr_err for one cycle.
REQ-032 SHALL sustain back-to-back accesses every cycle with no bubbles.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force to zero: out_ports, rdata, rd_valid, wr_strobe, rd_strobe, chg_flags, addr_err, synchronizer flops and previous-value registers.
REQ-034 SHALL cancel an access in flight when reset asserts mid-operation, with strobes dropping immediately and not firing after release.
REQ-035 SHALL accept the first access on the first rising edge after rst_n deasserts.
REQ-036 SHALL NOT set any chg_flags bit because of reset release itself.

Verification
REQ-037 SHALL cover: defaults, wr_en=1, addr=5, wdata=0xA -> out_ports[23:20]=0xA; wr_strobe=16'h0020 for exactly 1 cycle, then 0.
REQ-038 SHALL cover: in_ports slice 3 changes 0->0x7, wait 3 cycles, rd_en=1, addr=3 -> chg_flags[3]=1 before the read; next cycle rdata=0x7, rd_valid=1, rd_strobe=16'h0008; chg_flags[3]=0.
REQ-039 SHALL cover: NPORTS=12, wr_en=1, addr=13 -> addr_err pulses 1 cycle; out_ports unchanged; wr_strobe=0.
REQ-040 SHALL cover: wr_en=rd_en=1, addr=2, wdata=0x5, in slice 2 synchronized at 0xC -> out slice 2=0x5, rdata=0xC, both strobes=16'h0004.
REQ-041 SHALL cover: slice 1 toggles on the same edge as a read of port 1 -> chg_flags[1] remains 1.
REQ-042 SHALL cover: rst_n low mid-burst with out_ports nonzero -> all outputs 0 immediately; first write after release latches correctly.
